rr_onehot_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource among N requesters.
- Presents the winner both as a binary index and as its one-hot decode.
- Sits in front of the binary-to-one-hot select path and sequences ownership: grant, hold, release, rotate.
- Bounds hold time with a forced-release (timeout) counter so a stuck owner cannot starve the others.

---
 rtl/arb_pkg.sv | 30 +++
 rtl/rr_pick.sv | 44 ++++
 rtl/rr_onehot_arbiter.sv | 123 ++++++++++++
 tb/tb_rr_onehot_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Purpose  : Shared types and helpers for the round-robin one-hot arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int MAX_N     = 16;
    localparam int MAX_IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Binary-to-one-hot decode shared with the downstream select path.
    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        return MAX_N'(1) << idx;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational circular priority search starting at ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam logic [IDX_W:0] C_N = (IDX_W + 1)'(N);

    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_offset;
    logic [IDX_W:0]   w_sum;

    // Rotate so that bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin
        w_rot    = N'({req, req} >> ptr);
        w_offset = '0;
        any      = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_offset = IDX_W'(i);
                any      = 1'b1;
            end
        end
        w_sum = {1'b0, ptr} + {1'b0, w_offset};
        if (w_sum >= C_N) begin
            w_sum = w_sum - C_N;
        end
        idx = w_sum[IDX_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/rr_onehot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_onehot_arbiter
// Purpose  : Round-robin arbiter with one-hot/binary grant and forced release.
// Revision : 1.0 - initial release
// ============================================================================
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic             done_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             timeout_o
);

    generate
        if (IDX_W != clog2(N) || N < 2 || N > MAX_N) begin : g_bad_width
            $error("rr_onehot_arbiter: IDX_W must equal clog2(N), N in 2..16");
        end
        if (MAX_HOLD < 1 || MAX_HOLD > 255 || MAX_HOLD >= (1 << CNT_W)) begin : g_bad_hold
            $error("rr_onehot_arbiter: MAX_HOLD out of range for CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(N - 1);

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic [N-1:0]     r_gnt;

    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_owner_req;
    logic             w_release;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req_i),
        .ptr (r_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    assign w_owner_req = req_i[r_idx];
    assign w_release   = done_i | ~w_owner_req | (r_cnt == C_HOLD_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_valid_nxt   = r_valid;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = BUSY;
                    w_idx_nxt   = w_pick_idx;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_state_nxt   = IDLE;
                    w_valid_nxt   = 1'b0;
                    w_ptr_nxt     = (r_idx == C_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
                    // Only a pure counter expiry is flagged; done or withdraw wins a tie.
                    w_timeout_nxt = ~done_i & w_owner_req;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_gnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
            r_gnt     <= w_valid_nxt ? N'(onehot(MAX_IDX_W'(w_idx_nxt))) : '0;
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_idx_o   = r_idx;
    assign gnt_valid_o = r_valid;
    assign timeout_o   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_onehot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_onehot_arbiter
// Purpose  : Self-checking bench for rr_onehot_arbiter (N=4, MAX_HOLD=15).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_onehot_arbiter;

    localparam int N        = 4;
    localparam int IDX_W    = 2;
    localparam int MAX_HOLD = 15;
    localparam int CNT_W    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic             tmo;

    always #5 clk = ~clk;

    rr_onehot_arbiter #(
        .N        (N),
        .IDX_W    (IDX_W),
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .done_i      (done),
        .gnt_o       (gnt),
        .gnt_idx_o   (idx),
        .gnt_valid_o (valid),
        .timeout_o   (tmo)
    );

    typedef struct {
        logic             rst;
        logic [N-1:0]     req;
        logic             done;
        logic [N-1:0]     gnt;
        logic [IDX_W-1:0] idx;
        logic             valid;
        logic             tmo;
        string            name;
    } vec_t;

    typedef struct {
        logic [N-1:0]     gnt;
        logic [IDX_W-1:0] idx;
        logic             valid;
        logic             tmo;
        string            name;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic r, input logic [N-1:0] rq, input logic d,
                                input logic [N-1:0] eg, input logic [IDX_W-1:0] ei,
                                input logic ev, input logic et, input string nm);
        vec_t v;
        v.rst = r; v.req = rq; v.done = d;
        v.gnt = eg; v.idx = ei; v.valid = ev; v.tmo = et; v.name = nm;
        return v;
    endfunction

    task automatic check_out();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got output with no expected entry");
            return;
        end
        e = sb.pop_front();
        if ({gnt, idx, valid, tmo} !== {e.gnt, e.idx, e.valid, e.tmo}) begin
            errors++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b, want gnt=%b idx=%0d valid=%b timeout=%b",
                     e.name, gnt, idx, valid, tmo, e.gnt, e.idx, e.valid, e.tmo);
        end
    endtask

    // Drive one cycle of inputs, queue what must appear after the next edge, then check it.
    task automatic step(input vec_t v);
        exp_t e;
        rst  = v.rst;
        req  = v.req;
        done = v.done;
        e.gnt = v.gnt; e.idx = v.idx; e.valid = v.valid; e.tmo = v.tmo; e.name = v.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        int order[4];
        logic [N-1:0] oh;

        rst = 1'b1; req = '0; done = 1'b0;

        // Reset, single request, wrap from ptr 3, done ignored in IDLE, reset mid-grant.
        tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "reset_0"));
        tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "reset_1"));
        tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "single_grant"));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0000, 2'd2, 0, 0, "single_done"));
        tbl.push_back(mk(0, 4'b0011, 0, 4'b0001, 2'd0, 1, 0, "wrap_ptr3_to_0"));
        tbl.push_back(mk(0, 4'b0011, 1, 4'b0000, 2'd0, 0, 0, "wrap_done"));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 0, "idle_done_ignored"));
        tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "idle_stays"));
        tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "owner2_grant"));
        tbl.push_back(mk(1, 4'b0100, 0, 4'b0000, 2'd0, 0, 0, "reset_mid_grant"));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0, "post_reset_ptr0"));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0, "post_reset_done"));
        foreach (tbl[i]) step(tbl[i]);

        // Round robin with all requesting: ptr=1 now, so order 1,2,3,0 then 1.
        order = '{1, 2, 3, 0};
        for (int k = 0; k < 4; k++) begin
            oh = 4'b0001 << order[k];
            step(mk(0, 4'b1111, 0, oh, IDX_W'(order[k]), 1, 0, "rr_grant"));
            step(mk(0, 4'b1111, 0, oh, IDX_W'(order[k]), 1, 0, "rr_hold_others_ignored"));
            step(mk(0, 4'b1111, 1, 4'b0000, IDX_W'(order[k]), 0, 0, "rr_guard"));
        end

        // Timeout: sole requester 1 held, no done. Visible for exactly MAX_HOLD cycles.
        for (int t = 0; t < MAX_HOLD; t++) begin
            step(mk(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, "timeout_hold"));
        end
        step(mk(0, 4'b0010, 0, 4'b0000, 2'd1, 0, 1, "timeout_release"));
        step(mk(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, "timeout_regrant_same"));

        // done arriving on the last hold cycle is a normal release.
        for (int t = 0; t < MAX_HOLD - 1; t++) begin
            step(mk(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, "tie_hold"));
        end
        step(mk(0, 4'b0010, 1, 4'b0000, 2'd1, 0, 0, "tie_done_no_timeout"));

        // Owner withdraw: ptr=2, owner 3 drops its request; ptr then 0 so 1010 picks 1.
        step(mk(0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, "withdraw_grant3"));
        step(mk(0, 4'b1111, 0, 4'b1000, 2'd3, 1, 0, "withdraw_others_ignored"));
        step(mk(0, 4'b0111, 0, 4'b0000, 2'd3, 0, 0, "withdraw_release"));
        step(mk(0, 4'b1010, 0, 4'b0010, 2'd1, 1, 0, "withdraw_ptr0"));
        step(mk(0, 4'b0000, 0, 4'b0000, 2'd1, 0, 0, "withdraw_idx_holds"));

        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
